// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the core control path
// (decoder result enums, sequencer state encoding, trap cause codes).
package core_pkg;

  typedef enum logic [2:0] {
    CTRL_ALU,
    CTRL_BRANCH,
    CTRL_JUMP,
    CTRL_MEM,
    CTRL_AMO,
    CTRL_SYSTEM
  } ctrl_path_e;

  typedef enum logic [1:0] {
    ENG_ALU,
    ENG_MUL,
    ENG_DIV
  } exec_engine_e;

  typedef enum logic [1:0] {
    MEM_NONE,
    MEM_READ,
    MEM_WRITE
  } mem_dir_e;

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC,
    S_WAIT,
    S_MEM,
    S_AMO_RD,
    S_AMO_WR,
    S_TRAP
  } seq_state_e;

  localparam int unsigned CAUSE_IFAULT   = 1;
  localparam int unsigned CAUSE_ILLEGAL  = 2;
  localparam int unsigned CAUSE_BREAK    = 3;
  localparam int unsigned CAUSE_LFAULT   = 5;
  localparam int unsigned CAUSE_SFAULT   = 7;
  localparam int unsigned CAUSE_ECALL    = 8;
  // Interrupt code; the sequencer adds the interrupt flag in the cause MSB.
  localparam int unsigned CAUSE_IRQ_CODE = 3;

endpackage

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle control FSM that sequences fetch, execute,
// memory/AMO accesses, retirement and traps for a single-issue core.
module core_sequencer
  import core_pkg::*;
#(
  parameter int CAUSE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               fetch_req,
  input  logic               fetch_ready,
  input  logic [31:0]        fetch_rdata,
  input  logic               fetch_error,
  output logic [31:0]        instr,
  output logic               exec_phase,
  input  ctrl_path_e         ctrl_path,
  input  exec_engine_e       exec_engine,
  input  mem_dir_e           mem_dir,
  input  logic               illegal_instr,
  input  logic               ecall,
  input  logic               ebreak,
  output logic               exec_start,
  input  logic               exec_done,
  output logic               mem_req,
  input  logic               mem_done,
  input  logic               mem_error,
  input  logic               irq_pending,
  output logic               commit,
  output logic               trap,
  output logic [CAUSE_W-1:0] trap_cause
);

  localparam logic [31:0]        NOP_INSTR = 32'h00000013;
  localparam logic [CAUSE_W-1:0] IRQ_CAUSE = {1'b1, (CAUSE_W-1)'(CAUSE_IRQ_CODE)};

  seq_state_e         r_state;
  seq_state_e         w_nextState;
  logic               r_armed;
  logic [31:0]        r_instr;
  logic [CAUSE_W-1:0] r_cause;
  logic [CAUSE_W-1:0] w_nextCause;
  logic               w_loadInstr;
  logic               w_commit;
  logic               w_isMulDiv;

  assign w_isMulDiv = (exec_engine == ENG_MUL) || (exec_engine == ENG_DIV);
  assign instr      = r_instr;
  assign trap_cause = r_cause;
  assign commit     = w_commit;

  // r_armed keeps fetch_req low during reset and for the first cycle after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_armed <= 1'b0;
      r_instr <= NOP_INSTR;
      r_cause <= '0;
    end else begin
      r_state <= w_nextState;
      r_armed <= 1'b1;
      r_cause <= w_nextCause;
      if (w_loadInstr) begin
        r_instr <= fetch_rdata;
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextCause = r_cause;
    w_loadInstr = 1'b0;
    w_commit    = 1'b0;
    fetch_req   = 1'b0;
    mem_req     = 1'b0;
    exec_start  = 1'b0;
    exec_phase  = 1'b0;
    trap        = 1'b0;

    case (r_state)
      S_FETCH: begin
        if (r_armed) begin
          fetch_req = 1'b1;
          if (fetch_error) begin
            w_nextState = S_TRAP;
            w_nextCause = CAUSE_W'(CAUSE_IFAULT);
          end else if (fetch_ready) begin
            w_loadInstr = 1'b1;
            w_nextState = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        if (illegal_instr) begin
          w_nextState = S_TRAP;
          w_nextCause = CAUSE_W'(CAUSE_ILLEGAL);
        end else if (ebreak) begin
          w_nextState = S_TRAP;
          w_nextCause = CAUSE_W'(CAUSE_BREAK);
        end else if (ecall) begin
          w_nextState = S_TRAP;
          w_nextCause = CAUSE_W'(CAUSE_ECALL);
        end else if (ctrl_path == CTRL_MEM) begin
          w_nextState = S_MEM;
        end else if (ctrl_path == CTRL_AMO) begin
          w_nextState = S_AMO_RD;
        end else if (w_isMulDiv) begin
          exec_start  = 1'b1;
          w_nextState = S_WAIT;
        end else begin
          w_commit = 1'b1;
        end
      end
      S_WAIT: begin
        if (exec_done) begin
          w_commit = 1'b1;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        if (mem_error) begin
          w_nextState = S_TRAP;
          w_nextCause = (mem_dir == MEM_READ) ? CAUSE_W'(CAUSE_LFAULT)
                                              : CAUSE_W'(CAUSE_SFAULT);
        end else if (mem_done) begin
          w_commit = 1'b1;
        end
      end
      S_AMO_RD: begin
        mem_req = 1'b1;
        if (mem_error) begin
          w_nextState = S_TRAP;
          w_nextCause = CAUSE_W'(CAUSE_SFAULT);
        end else if (mem_done) begin
          w_nextState = S_AMO_WR;
        end
      end
      S_AMO_WR: begin
        mem_req    = 1'b1;
        exec_phase = 1'b1;
        if (mem_error) begin
          w_nextState = S_TRAP;
          w_nextCause = CAUSE_W'(CAUSE_SFAULT);
        end else if (mem_done) begin
          w_commit = 1'b1;
        end
      end
      S_TRAP: begin
        trap        = 1'b1;
        w_nextState = S_FETCH;
      end
      default: begin
        w_nextState = S_FETCH;
      end
    endcase

    // Interrupts are only taken at an instruction boundary, i.e. on retire.
    if (w_commit) begin
      if (irq_pending) begin
        w_nextState = S_TRAP;
        w_nextCause = IRQ_CAUSE;
      end else begin
        w_nextState = S_FETCH;
      end
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: table-driven and randomized transaction-level checks of
// core_sequencer against an outcome model built from the sequencing rules.
module tb_core_sequencer;
  import core_pkg::*;

  typedef struct {
    string        name;
    logic         fetchErr;
    logic         fetchBoth;
    logic         illegal;
    logic         ebreakF;
    logic         ecallF;
    logic         irq;
    ctrl_path_e   ctrl;
    exec_engine_e eng;
    mem_dir_e     dir;
    int           errPhase;
    int           fetchDelay;
    int           memDelay;
    int           divDelay;
    logic [31:0]  word;
    int           eCommit;
    int           eCause;
    int           eStarts;
  } vec_t;

  logic         clk;
  logic         rstN;
  logic         fetchReq;
  logic         fetchReady;
  logic [31:0]  fetchRdata;
  logic         fetchError;
  logic [31:0]  instrOut;
  logic         execPhase;
  ctrl_path_e   ctrlPath;
  exec_engine_e execEngine;
  mem_dir_e     memDir;
  logic         illegalInstr;
  logic         ecallIn;
  logic         ebreakIn;
  logic         execStart;
  logic         execDone;
  logic         memReq;
  logic         memDone;
  logic         memError;
  logic         irqPending;
  logic         commit;
  logic         trap;
  logic [3:0]   trapCause;

  int           errors = 0;
  int           checks = 0;
  int           invViol = 0;
  logic [31:0]  expInstr = 32'h00000013;
  vec_t         vecs[$];

  core_sequencer #(.CAUSE_W(4)) dut (
    .clk(clk), .rst_n(rstN),
    .fetch_req(fetchReq), .fetch_ready(fetchReady), .fetch_rdata(fetchRdata),
    .fetch_error(fetchError), .instr(instrOut), .exec_phase(execPhase),
    .ctrl_path(ctrlPath), .exec_engine(execEngine), .mem_dir(memDir),
    .illegal_instr(illegalInstr), .ecall(ecallIn), .ebreak(ebreakIn),
    .exec_start(execStart), .exec_done(execDone),
    .mem_req(memReq), .mem_done(memDone), .mem_error(memError),
    .irq_pending(irqPending), .commit(commit), .trap(trap), .trap_cause(trapCause)
  );

  // Free-running 10ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  // Flags packed as {fetchErr, illegal, ebreak, ecall, irq}; fetch errors also raise fetch_ready.
  function automatic vec_t mkVec(input string n, input logic [4:0] flags, input ctrl_path_e c,
                                 input exec_engine_e e, input mem_dir_e d, input int errPh,
                                 input int fD, input int mD, input int dD, input logic [31:0] w,
                                 input int eC, input int eCa, input int eS);
    vec_t v;
    v.name = n; v.fetchErr = flags[4]; v.fetchBoth = 1'b1; v.illegal = flags[3];
    v.ebreakF = flags[2]; v.ecallF = flags[1]; v.irq = flags[0];
    v.ctrl = c; v.eng = e; v.dir = d; v.errPhase = errPh;
    v.fetchDelay = fD; v.memDelay = mD; v.divDelay = dD; v.word = w;
    v.eCommit = eC; v.eCause = eCa; v.eStarts = eS;
    return v;
  endfunction

  // Reference outcome of one instruction: commit, trap cause and engine starts.
  function automatic void predict(inout vec_t v);
    v.eCommit = 0; v.eCause = 0; v.eStarts = 0;
    if (v.fetchErr)      v.eCause = 1;
    else if (v.illegal)  v.eCause = 2;
    else if (v.ebreakF)  v.eCause = 3;
    else if (v.ecallF)   v.eCause = 8;
    else if (v.ctrl == CTRL_MEM && v.errPhase == 1) v.eCause = (v.dir == MEM_READ) ? 5 : 7;
    else if (v.ctrl == CTRL_AMO && v.errPhase inside {1, 2}) v.eCause = 7;
    else begin
      v.eCommit = 1;
      if (v.ctrl != CTRL_MEM && v.ctrl != CTRL_AMO && v.eng inside {ENG_MUL, ENG_DIV}) v.eStarts = 1;
      if (v.irq) v.eCause = 8 + 3;
    end
  endfunction

  // Expected count of mem_req cycles in the read (phase 0) and write (phase 1) halves.
  function automatic void expPhases(input vec_t v, output int p0, output int p1);
    bit reached;
    reached = !v.fetchErr && !v.illegal && !v.ebreakF && !v.ecallF;
    p0 = 0; p1 = 0;
    if (reached && (v.ctrl == CTRL_MEM || v.ctrl == CTRL_AMO)) p0 = v.memDelay;
    if (reached && v.ctrl == CTRL_AMO && v.errPhase != 1) p1 = v.memDelay;
  endfunction

  // Runs one instruction from fetch to retire/trap, acting as memory, fetch unit and engine.
  task automatic applyStimulus(input vec_t v);
    int fetchCnt = 0, memCnt = 0, phaseCnt = 0, divCnt = 0;
    int commits = 0, starts = 0, cause = 0, p0 = 0, p1 = 0, eP0, eP1;
    int fetchCyc = -1, commitCyc = -1, doneCyc = -1;
    bit started = 0, finished = 0, commitSeen = 0;
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      @(negedge clk);
      fetchReady = 0; fetchError = 0; memDone = 0; memError = 0; execDone = 0;
      illegalInstr = v.illegal; ebreakIn = v.ebreakF; ecallIn = v.ecallF;
      ctrlPath = v.ctrl; execEngine = v.eng; memDir = v.dir; irqPending = v.irq;
      #1;
      if (cyc == 0) checkOutput({v.name, ":fetch_req_start"}, fetchReq, 1);
      if (fetchReq) begin
        fetchCnt++;
        if (fetchCnt == v.fetchDelay) begin
          fetchRdata = v.word;
          fetchError = v.fetchErr;
          fetchReady = v.fetchErr ? v.fetchBoth : 1'b1;
          fetchCyc = cyc;
        end
      end
      if (memReq) begin
        if (execPhase) p1++; else p0++;
        memCnt++;
        if (memCnt == v.memDelay) begin
          memCnt = 0; phaseCnt++;
          memDone = 1; memError = (phaseCnt == v.errPhase);
        end
      end
      if (started) begin
        divCnt++;
        if (divCnt == v.divDelay) begin execDone = 1; doneCyc = cyc; end
      end
      if (execStart) begin starts++; started = 1; end
      #1;
      if (commit && trap) invViol++;
      if (fetchReq && memReq) invViol++;
      if (execPhase && !memReq) invViol++;
      if (commitSeen && v.irq) finished = 1;
      if (commit) begin
        commits++; commitCyc = cyc; commitSeen = 1;
        if (!v.irq) finished = 1;
      end
      if (trap) begin cause = trapCause; finished = 1; end
    end
    if (!v.fetchErr) expInstr = v.word;
    expPhases(v, eP0, eP1);
    checkOutput({v.name, ":timeout"}, finished, 1);
    checkOutput({v.name, ":commit"}, commits, v.eCommit);
    checkOutput({v.name, ":cause"}, cause, v.eCause);
    checkOutput({v.name, ":exec_start"}, starts, v.eStarts);
    checkOutput({v.name, ":instr"}, instrOut, expInstr);
    checkOutput({v.name, ":phase0"}, p0, eP0);
    checkOutput({v.name, ":phase1"}, p1, eP1);
    if (v.eCommit == 1 && v.eStarts == 0 && eP0 == 0)
      checkOutput({v.name, ":alu_latency"}, commitCyc - fetchCyc, 1);
    if (v.eStarts == 1)
      checkOutput({v.name, ":commit_on_done"}, commitCyc, doneCyc);
  endtask

  task automatic checkAllIdle(input string tag);
    checkOutput({tag, ":fetch_req"}, fetchReq, 0);
    checkOutput({tag, ":mem_req"}, memReq, 0);
    checkOutput({tag, ":exec_start"}, execStart, 0);
    checkOutput({tag, ":exec_phase"}, execPhase, 0);
    checkOutput({tag, ":commit"}, commit, 0);
    checkOutput({tag, ":trap"}, trap, 0);
    checkOutput({tag, ":trap_cause"}, trapCause, 0);
    checkOutput({tag, ":instr"}, instrOut, 32'h00000013);
  endtask

  // Reset dropped while the AMO write access is outstanding.
  task automatic resetMidAmo();
    @(negedge clk);
    illegalInstr = 0; ebreakIn = 0; ecallIn = 0; irqPending = 0;
    ctrlPath = CTRL_AMO; execEngine = ENG_ALU; memDir = MEM_WRITE;
    memDone = 0; memError = 0; execDone = 0; fetchError = 0;
    fetchRdata = 32'h00c5a52f; fetchReady = 1;
    #1 checkOutput("rstamo:fetch_req", fetchReq, 1);
    @(negedge clk); fetchReady = 0;
    #1 checkOutput("rstamo:exec_mem_req", memReq, 0);
    @(negedge clk); memDone = 1;
    #1 checkOutput("rstamo:rd_mem_req", memReq, 1);
    checkOutput("rstamo:rd_phase", execPhase, 0);
    @(negedge clk); memDone = 0;
    #1 checkOutput("rstamo:wr_phase", execPhase, 1);
    #2 rstN = 0;
    #1 checkAllIdle("rstamo_in_reset");
    @(negedge clk);
    #1 checkAllIdle("rstamo_held");
    rstN = 1;
    #1 checkOutput("rstamo:release_fetch_req", fetchReq, 0);
    @(negedge clk);
    #1 checkOutput("rstamo:restart_fetch_req", fetchReq, 1);
    expInstr = 32'h00000013;
  endtask

  initial begin
    vec_t v;
    logic [2:0] rc;
    rstN = 0; fetchReady = 0; fetchRdata = '0; fetchError = 0;
    ctrlPath = CTRL_ALU; execEngine = ENG_ALU; memDir = MEM_NONE;
    illegalInstr = 0; ecallIn = 0; ebreakIn = 0;
    execDone = 0; memDone = 0; memError = 0; irqPending = 0;
    #12 checkAllIdle("reset");
    @(negedge clk); rstN = 1;
    #1 checkOutput("release:fetch_req", fetchReq, 0);

    vecs.push_back(mkVec("addi",       5'b00000, CTRL_ALU, ENG_ALU, MEM_NONE,  0, 3, 1, 1,  32'h00a00093, 1, 0,  0));
    vecs.push_back(mkVec("div33",      5'b00000, CTRL_ALU, ENG_DIV, MEM_NONE,  0, 1, 1, 33, 32'h02c5c533, 1, 0,  1));
    vecs.push_back(mkVec("amoadd",     5'b00000, CTRL_AMO, ENG_ALU, MEM_WRITE, 0, 1, 2, 1,  32'h00c5a52f, 1, 0,  0));
    vecs.push_back(mkVec("load_err",   5'b00000, CTRL_MEM, ENG_ALU, MEM_READ,  1, 1, 2, 1,  32'h0005a503, 0, 5,  0));
    vecs.push_back(mkVec("store_err",  5'b00000, CTRL_MEM, ENG_ALU, MEM_WRITE, 1, 2, 1, 1,  32'h00a5a023, 0, 7,  0));
    vecs.push_back(mkVec("ill_ecall",  5'b01010, CTRL_ALU, ENG_ALU, MEM_NONE,  0, 1, 1, 1,  32'hffffffff, 0, 2,  0));
    vecs.push_back(mkVec("irq_commit", 5'b00001, CTRL_ALU, ENG_ALU, MEM_NONE,  0, 1, 1, 1,  32'h00100093, 1, 11, 0));
    vecs.push_back(mkVec("fetch_err",  5'b10000, CTRL_ALU, ENG_ALU, MEM_NONE,  0, 2, 1, 1,  32'hdeadbeef, 0, 1,  0));
    vecs.push_back(mkVec("ebrk_ecall", 5'b00110, CTRL_ALU, ENG_ALU, MEM_NONE,  0, 1, 1, 1,  32'h00100073, 0, 3,  0));
    vecs.push_back(mkVec("ecall",      5'b00010, CTRL_SYSTEM, ENG_ALU, MEM_NONE, 0, 1, 1, 1, 32'h00000073, 0, 8, 0));
    vecs.push_back(mkVec("amo_wr_err", 5'b00000, CTRL_AMO, ENG_ALU, MEM_WRITE, 2, 1, 3, 1,  32'h00c5a52f, 0, 7,  0));
    vecs.push_back(mkVec("amo_rd_err", 5'b00000, CTRL_AMO, ENG_ALU, MEM_WRITE, 1, 1, 1, 1,  32'h00c5a52f, 0, 7,  0));
    vecs.push_back(mkVec("mul_irq",    5'b00001, CTRL_ALU, ENG_MUL, MEM_NONE,  0, 1, 1, 4,  32'h02c58533, 1, 11, 1));
    vecs.push_back(mkVec("load_ok",    5'b00000, CTRL_MEM, ENG_ALU, MEM_READ,  0, 1, 3, 1,  32'h0045a503, 1, 0,  0));
    vecs.push_back(mkVec("mem_vs_mul", 5'b00000, CTRL_MEM, ENG_MUL, MEM_READ,  0, 1, 1, 1,  32'h0085a503, 1, 0,  0));
    foreach (vecs[i]) applyStimulus(vecs[i]);

    resetMidAmo();

    for (int i = 0; i < 150; i++) begin
      v.name = $sformatf("rnd%0d", i);
      v.fetchErr  = ($urandom_range(0, 9) == 0);
      v.fetchBoth = $urandom_range(0, 1) == 1;
      v.illegal   = ($urandom_range(0, 7) == 0);
      v.ebreakF   = ($urandom_range(0, 7) == 0);
      v.ecallF    = ($urandom_range(0, 7) == 0);
      v.irq       = ($urandom_range(0, 3) == 0);
      rc = 3'($urandom_range(0, 5));
      v.ctrl = ctrl_path_e'(rc);
      v.eng  = exec_engine_e'(2'($urandom_range(0, 2)));
      v.dir  = mem_dir_e'(2'($urandom_range(1, 2)));
      v.errPhase   = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 2));
      v.fetchDelay = $urandom_range(1, 4);
      v.memDelay   = $urandom_range(1, 4);
      v.divDelay   = $urandom_range(1, 6);
      v.word       = $urandom;
      predict(v);
      applyStimulus(v);
    end

    checkOutput("invariants", invViol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
